lc3_mem_responder: RTL and testbench

//  Parametrised dual-port memory responder that answers LC3 fetch and memaccess requests.

---
 rtl/lc3_mem_pkg.sv | 17 +
 rtl/lc3_mem_port.sv | 126 ++++++++++++
 rtl/lc3_mem_responder.sv | 80 ++++++++
 tb/tb_lc3_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 memory responder and its per-port engine.
package lc3_mem_pkg;

    localparam int MAX_LAT = 15;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        DONE = ST_DONE
    } port_state_t;

endpackage

// File: rtl/lc3_mem_port.sv
// One memory port: request FSM with programmable wait states, a private storage array
// and a backdoor write path. WRITABLE=0 turns it into a read-only (fetch) port.
module lc3_mem_port
    import lc3_mem_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int DEPTH_LG = 8,
    parameter int LAT      = 0,
    parameter bit WRITABLE = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req,
    input  logic                rd,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       din,
    input  logic                bd_we,
    input  logic [DEPTH_LG-1:0] bd_addr,
    input  logic [DW-1:0]       bd_data,
    output logic [DW-1:0]       dout,
    output logic                complete,
    output logic                busy
);

    localparam int DEPTH = 1 << DEPTH_LG;
    localparam logic [CNT_W-1:0] LAT_LOAD = (LAT > 0) ? CNT_W'(LAT - 1) : '0;

    port_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DEPTH_LG-1:0] idx_q, req_idx, done_idx;
    logic                rd_q, rd_eff, done_rd;
    logic [DW-1:0]       din_q, done_din, rdata_q;
    logic                enter_done, mem_wr;
    logic [DW-1:0]       mem [DEPTH];

    // An unknown address is steered to index 0 so a stray X cannot spread into the array.
    assign req_idx = $isunknown(addr) ? '0 : addr[DEPTH_LG-1:0];
    assign rd_eff  = WRITABLE ? rd : 1'b1;

    // With zero wait states DONE is entered straight from IDLE, so use the live request.
    assign done_idx = (state_q == IDLE) ? req_idx : idx_q;
    assign done_rd  = (state_q == IDLE) ? rd_eff  : rd_q;
    assign done_din = (state_q == IDLE) ? din     : din_q;

    assign enter_done = (state_d == DONE) && (state_q != DONE);
    assign mem_wr     = WRITABLE && reset && enter_done && !done_rd;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LAT == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        complete = (state_q == DONE);
        dout     = complete ? rdata_q : '0;
        busy     = (state_q != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            rd_q    <= 1'b1;
            din_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && req) begin
                idx_q <= req_idx;
                rd_q  <= rd_eff;
                din_q <= din;
            end
            if (enter_done) begin
                rdata_q <= done_rd ? mem[done_idx] : '0;
            end
        end
    end

    // Storage survives reset; the backdoor assignment comes last so it wins a same-index collision.
    always_ff @(posedge clock) begin
        if (mem_wr) begin
            mem[done_idx] <= done_din;
        end
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && state_q == IDLE && req) begin
            assert (!$isunknown(addr))
            else $error("lc3_mem_port: unknown address with request asserted");
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// Dual-port LC3 memory responder: read-only instruction port plus load/store data port,
// each with its own wait-state count, sharing one backdoor preload interface.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int DEPTH_LG = 8,
    parameter int I_LAT    = 0,
    parameter int D_LAT    = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                instrmem_rd,
    input  logic [AW-1:0]       pc,
    output logic [DW-1:0]       Instr_dout,
    output logic                complete_instr,
    input  logic                Data_req,
    input  logic                Data_rd,
    input  logic [AW-1:0]       Data_addr,
    input  logic [DW-1:0]       Data_din,
    output logic [DW-1:0]       Data_dout,
    output logic                complete_data,
    input  logic                bd_we,
    input  logic                bd_sel,
    input  logic [DEPTH_LG-1:0] bd_addr,
    input  logic [DW-1:0]       bd_data,
    output logic [1:0]          busy
);

    logic i_bd_we, d_bd_we;
    logic i_busy, d_busy;

    assign i_bd_we = bd_we && !bd_sel;
    assign d_bd_we = bd_we &&  bd_sel;
    assign busy    = {d_busy, i_busy};

    lc3_mem_port #(
        .DW       (DW),
        .AW       (AW),
        .DEPTH_LG (DEPTH_LG),
        .LAT      (I_LAT),
        .WRITABLE (1'b0)
    ) u_iport (
        .clock    (clock),
        .reset    (reset),
        .req      (instrmem_rd),
        .rd       (1'b1),
        .addr     (pc),
        .din      ({DW{1'b0}}),
        .bd_we    (i_bd_we),
        .bd_addr  (bd_addr),
        .bd_data  (bd_data),
        .dout     (Instr_dout),
        .complete (complete_instr),
        .busy     (i_busy)
    );

    lc3_mem_port #(
        .DW       (DW),
        .AW       (AW),
        .DEPTH_LG (DEPTH_LG),
        .LAT      (D_LAT),
        .WRITABLE (1'b1)
    ) u_dport (
        .clock    (clock),
        .reset    (reset),
        .req      (Data_req),
        .rd       (Data_rd),
        .addr     (Data_addr),
        .din      (Data_din),
        .bd_we    (d_bd_we),
        .bd_addr  (bd_addr),
        .bd_data  (bd_data),
        .dout     (Data_dout),
        .complete (complete_data),
        .busy     (d_busy)
    );

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: two instances (latencies 0/2 and 1/3) share stimulus and are
// checked every cycle against a timestamp-based reference model, plus directed literal checks.
module tb_lc3_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instrmem_rd = 1'b0;
    logic [15:0] pc = '0;
    logic        Data_req = 1'b0;
    logic        Data_rd = 1'b0;
    logic [15:0] Data_addr = '0;
    logic [15:0] Data_din = '0;
    logic        bd_we = 1'b0;
    logic        bd_sel = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [15:0] bd_data = '0;

    logic [15:0] instr_dout_w [2];
    logic        complete_instr_w [2];
    logic [15:0] data_dout_w [2];
    logic        complete_data_w [2];
    logic [1:0]  busy_w [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    lc3_mem_responder #(.DW(16), .AW(16), .DEPTH_LG(8), .I_LAT(0), .D_LAT(2)) dut_a (
        .clock(clock), .reset(reset),
        .instrmem_rd(instrmem_rd), .pc(pc),
        .Instr_dout(instr_dout_w[0]), .complete_instr(complete_instr_w[0]),
        .Data_req(Data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
        .Data_dout(data_dout_w[0]), .complete_data(complete_data_w[0]),
        .bd_we(bd_we), .bd_sel(bd_sel), .bd_addr(bd_addr), .bd_data(bd_data),
        .busy(busy_w[0])
    );

    lc3_mem_responder #(.DW(16), .AW(16), .DEPTH_LG(8), .I_LAT(1), .D_LAT(3)) dut_b (
        .clock(clock), .reset(reset),
        .instrmem_rd(instrmem_rd), .pc(pc),
        .Instr_dout(instr_dout_w[1]), .complete_instr(complete_instr_w[1]),
        .Data_req(Data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
        .Data_dout(data_dout_w[1]), .complete_data(complete_data_w[1]),
        .bd_we(bd_we), .bd_sel(bd_sel), .bd_addr(bd_addr), .bd_data(bd_data),
        .busy(busy_w[1])
    );

    function automatic int lat_i(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic int lat_d(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: an access accepted at edge n completes (memory effect + pulse) at edge
    // n+LAT and the port accepts again from edge n+LAT+2.
    int          cyc = 0;
    int          i_due [2] = '{-10, -10};
    int          d_due [2] = '{-10, -10};
    logic [7:0]  i_idx [2];
    logic [7:0]  d_idx [2];
    logic        d_rd_m [2];
    logic [15:0] d_din_m [2];
    logic [15:0] m_imem [2][256];
    logic [15:0] m_dmem [2][256];
    logic        e_ci [2] = '{1'b0, 1'b0};
    logic        e_cd [2] = '{1'b0, 1'b0};
    logic [15:0] e_idout [2] = '{16'h0, 16'h0};
    logic [15:0] e_ddout [2] = '{16'h0, 16'h0};
    logic [1:0]  e_busy [2] = '{2'b00, 2'b00};

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            e_ci[k] = 1'b0;
            e_cd[k] = 1'b0;
            e_idout[k] = '0;
            e_ddout[k] = '0;
            if (!reset) begin
                i_due[k] = -10;
                d_due[k] = -10;
            end else begin
                if (instrmem_rd && cyc >= i_due[k] + 2) begin
                    i_due[k] = cyc + lat_i(k);
                    i_idx[k] = pc[7:0];
                end
                if (Data_req && cyc >= d_due[k] + 2) begin
                    d_due[k]   = cyc + lat_d(k);
                    d_idx[k]   = Data_addr[7:0];
                    d_rd_m[k]  = Data_rd;
                    d_din_m[k] = Data_din;
                end
                if (cyc == i_due[k]) begin
                    e_ci[k]    = 1'b1;
                    e_idout[k] = m_imem[k][i_idx[k]];
                end
                if (cyc == d_due[k]) begin
                    e_cd[k] = 1'b1;
                    if (d_rd_m[k]) e_ddout[k] = m_dmem[k][d_idx[k]];
                    else m_dmem[k][d_idx[k]] = d_din_m[k];
                end
            end
            if (bd_we) begin
                if (bd_sel) m_dmem[k][bd_addr] = bd_data;
                else m_imem[k][bd_addr] = bd_data;
            end
            e_busy[k] = {(cyc <= d_due[k]), (cyc <= i_due[k])};
        end
        cyc++;
    end

    always begin
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("complete_instr[%0d]", k), 32'(complete_instr_w[k]), 32'(e_ci[k]));
            check($sformatf("Instr_dout[%0d]", k), 32'(instr_dout_w[k]), 32'(e_idout[k]));
            check($sformatf("complete_data[%0d]", k), 32'(complete_data_w[k]), 32'(e_cd[k]));
            check($sformatf("Data_dout[%0d]", k), 32'(data_dout_w[k]), 32'(e_ddout[k]));
            check($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(e_busy[k]));
        end
    end

    // Inputs change 2 time units after the active edge; the compare process samples at +1.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic d_access(input logic rd, input logic [15:0] addr, input logic [15:0] din,
                            output logic [15:0] dout, output int lat);
        Data_req  = 1'b1;
        Data_rd   = rd;
        Data_addr = addr;
        Data_din  = din;
        lat  = -1;
        dout = '0;
        for (int s = 1; s <= 20 && lat < 0; s++) begin
            step();
            Data_req = 1'b0;
            if (complete_data_w[0]) begin
                lat  = s;
                dout = data_dout_w[0];
            end
        end
        step();
    endtask

    initial begin
        logic [15:0] dv;
        logic [15:0] cap;
        int          lat;
        int          pulses;
        int          ti;
        int          td;
        logic [15:0] ti_data;
        logic [15:0] td_data;

        repeat (3) step();
        check("reset_busy_a", 32'(busy_w[0]), 32'h0);
        check("reset_busy_b", 32'(busy_w[1]), 32'h0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 512; i++) begin
            bd_we   = 1'b1;
            bd_sel  = (i >= 256);
            bd_addr = 8'(i);
            bd_data = 16'($urandom());
            step();
        end
        bd_we = 1'b0;

        // Zero-wait fetch
        bd_we = 1'b1; bd_sel = 1'b0; bd_addr = 8'd3; bd_data = 16'h1261;
        step();
        bd_we = 1'b0;
        instrmem_rd = 1'b1; pc = 16'd3;
        step();
        instrmem_rd = 1'b0;
        check("fetch_pulse", 32'(complete_instr_w[0]), 32'h1);
        check("fetch_data", 32'(instr_dout_w[0]), 32'h1261);
        step();
        check("fetch_one_cycle", 32'(complete_instr_w[0]), 32'h0);
        repeat (3) step();

        d_access(1'b0, 16'h0040, 16'hBEEF, dv, lat);
        check("st_latency", 32'(lat), 32'd3);
        check("st_dout_zero", 32'(dv), 32'h0);
        d_access(1'b1, 16'h0040, 16'h0000, dv, lat);
        check("ld_latency", 32'(lat), 32'd3);
        check("ld_data", 32'(dv), 32'hBEEF);

        d_access(1'b0, 16'h0105, 16'h00AA, dv, lat);
        d_access(1'b1, 16'h0005, 16'h0000, dv, lat);
        check("wrap_ld_data", 32'(dv), 32'h00AA);
        repeat (4) step();

        // Second request while busy must be dropped
        pulses = 0; cap = '0;
        Data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h0040;
        step();
        if (complete_data_w[0]) pulses++;
        Data_addr = 16'h0005;
        step();
        Data_req = 1'b0;
        for (int s = 0; s < 9; s++) begin
            if (complete_data_w[0]) begin
                pulses++;
                cap = data_dout_w[0];
            end
            step();
        end
        check("busy_drop_pulses", 32'(pulses), 32'd1);
        check("busy_drop_data", 32'(cap), 32'hBEEF);

        // Backdoor write lands on the same edge as the port write to that index
        Data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h0077; Data_din = 16'h1111;
        step();
        Data_req = 1'b0;
        step();
        bd_we = 1'b1; bd_sel = 1'b1; bd_addr = 8'h77; bd_data = 16'h2222;
        step();
        bd_we = 1'b0;
        check("collision_pulse", 32'(complete_data_w[0]), 32'h1);
        step();
        d_access(1'b1, 16'h0077, 16'h0000, dv, lat);
        check("collision_bd_wins", 32'(dv), 32'h2222);
        repeat (6) step();

        // Concurrent fetch and load on the 1/3-latency instance
        ti = -1; td = -1; ti_data = '0; td_data = '0;
        instrmem_rd = 1'b1; pc = 16'd3;
        Data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h0040;
        for (int s = 1; s <= 8; s++) begin
            step();
            instrmem_rd = 1'b0;
            Data_req = 1'b0;
            if (complete_instr_w[1] && ti < 0) begin ti = s; ti_data = instr_dout_w[1]; end
            if (complete_data_w[1] && td < 0) begin td = s; td_data = data_dout_w[1]; end
        end
        check("conc_instr_lat", 32'(ti), 32'd2);
        check("conc_data_lat", 32'(td), 32'd4);
        check("conc_instr_data", 32'(ti_data), 32'h1261);
        check("conc_load_data", 32'(td_data), 32'hBEEF);
        repeat (4) step();

        // Reset while both ports of instance b sit in WAIT
        instrmem_rd = 1'b1; pc = 16'd3;
        Data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h0040;
        step();
        instrmem_rd = 1'b0;
        Data_req = 1'b0;
        check("pre_reset_busy_b", 32'(busy_w[1]), 32'h3);
        reset = 1'b0;
        #1;
        check("mid_reset_busy_b", 32'(busy_w[1]), 32'h0);
        check("mid_reset_busy_a", 32'(busy_w[0]), 32'h0);
        check("mid_reset_outs_b", {complete_instr_w[1], complete_data_w[1], 14'h0, data_dout_w[1] | instr_dout_w[1]}, 32'h0);
        pulses = 0;
        for (int s = 0; s < 8; s++) begin
            step();
            if (s == 2) reset = 1'b1;
            if (complete_instr_w[1] || complete_data_w[1]) pulses++;
        end
        check("reset_no_pulse", 32'(pulses), 32'd0);
        instrmem_rd = 1'b1; pc = 16'h0103;
        step();
        instrmem_rd = 1'b0;
        check("imem_kept_pulse", 32'(complete_instr_w[0]), 32'h1);
        check("imem_kept_data", 32'(instr_dout_w[0]), 32'h1261);
        repeat (4) step();

        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 299) != 0);
            instrmem_rd = ($urandom_range(0, 3) != 0);
            pc          = 16'($urandom()) & 16'hFF1F;
            Data_req    = ($urandom_range(0, 3) != 0);
            Data_rd     = 1'($urandom_range(0, 1));
            Data_addr   = 16'($urandom()) & 16'hF31F;
            Data_din    = 16'($urandom());
            bd_we       = ($urandom_range(0, 5) == 0);
            bd_sel      = 1'($urandom_range(0, 1));
            bd_addr     = 8'($urandom()) & 8'h1F;
            bd_data     = 16'($urandom());
            step();
        end
        reset = 1'b1;
        instrmem_rd = 1'b0;
        Data_req = 1'b0;
        bd_we = 1'b0;
        repeat (8) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
